// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES block packer: FSM encoding, default block size,
// and the byte-count width helper.
package aes_uart_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;

    typedef enum logic {
        StFill = 1'b0,
        StFull = 1'b1
    } pack_state_e;

    // Width able to hold 0..bytes inclusive.
    function automatic int unsigned cnt_width(input int unsigned bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage

// File: rtl/uart_pack_idle_timer.sv
// Idle counter for the block packer: clears on clr_i, counts while en_i, and flags
// expire_o in the cycle the count reaches CYCLES-1.
module uart_pack_idle_timer #(
    parameter int unsigned CYCLES = 20000
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [TW-1:0] LastCnt = TW'(CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        expire_o = en_i && (cnt_q == LastCnt);
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/uart_aes_block_packer.sv
// Packs UART RX bytes into AES blocks, double-buffered behind a valid/ready port.
// Define UART_PACK_TIMEOUT_EN to discard partial blocks after TIMEOUT_CYCLES idle clocks.
module uart_aes_block_packer
    import aes_uart_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES    = AES_BLOCK_BYTES,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                              i_Clock,
    input  logic                              i_Rst_L,
    input  logic                              rx_dv_i,
    input  logic [7:0]                        rx_byte_i,
    input  logic                              flush_i,
    output logic                              blk_valid_o,
    output logic [8*BLOCK_BYTES-1:0]          blk_data_o,
    input  logic                              blk_ready_i,
    output logic [cnt_width(BLOCK_BYTES)-1:0] byte_cnt_o,
    output logic                              overrun_o,
    input  logic                              overrun_clr_i,
    output logic                              timeout_o
);

    localparam int unsigned   CW      = cnt_width(BLOCK_BYTES);
    localparam int unsigned   DW      = 8 * BLOCK_BYTES;
    localparam logic [CW-1:0] LastIdx = CW'(BLOCK_BYTES - 1);
    localparam logic [CW-1:0] FullCnt = CW'(BLOCK_BYTES);

    pack_state_e   state_q, state_d;
    logic [DW-1:0] asm_q, asm_d, out_q, out_d, asm_wr;
    logic [CW-1:0] cnt_q, cnt_d, wr_idx;
    logic          valid_q, valid_d, overrun_q, overrun_d;
    logic          slot_free, byte_accept, overrun_set, idle_expire, last_byte;

    assign slot_free = !valid_q || blk_ready_i;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= StFill;
            asm_q     <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // A byte taken on a FULL->FILL transfer or on the expiry cycle starts a fresh block.
    always_comb begin
        wr_idx = (state_q == StFull || idle_expire) ? '0 : cnt_q;
        asm_wr = asm_q;
        for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
            if (wr_idx == CW'(i)) begin
                if (MSB_FIRST) begin
                    asm_wr[DW-1-8*i -: 8] = rx_byte_i;
                end else begin
                    asm_wr[8*i +: 8] = rx_byte_i;
                end
            end
        end
        last_byte = (wr_idx == LastIdx);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (!flush_i && rx_dv_i && last_byte && !slot_free) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (flush_i || slot_free) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        asm_d       = asm_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q && !blk_ready_i;
        byte_accept = 1'b0;
        overrun_set = 1'b0;
        unique case (state_q)
            StFill: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (rx_dv_i) begin
                    byte_accept = 1'b1;
                    asm_d       = asm_wr;
                    if (last_byte) begin
                        if (slot_free) begin
                            out_d   = asm_wr;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = FullCnt;
                        end
                    end else begin
                        cnt_d = wr_idx + CW'(1);
                    end
                end else if (idle_expire) begin
                    cnt_d = '0;
                end
            end
            StFull: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (slot_free) begin
                    out_d   = asm_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    if (rx_dv_i) begin
                        byte_accept = 1'b1;
                        asm_d       = asm_wr;
                        cnt_d       = CW'(1);
                    end
                end else if (rx_dv_i) begin
                    overrun_set = 1'b1;
                end
            end
            default: ;
        endcase
        overrun_d = overrun_set || (overrun_q && !overrun_clr_i);
    end

    always_comb begin
        blk_valid_o = valid_q;
        blk_data_o  = out_q;
        byte_cnt_o  = cnt_q;
        overrun_o   = overrun_q;
    end

`ifdef UART_PACK_TIMEOUT_EN
    logic timeout_q;

    uart_pack_idle_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .clr_i   (byte_accept || idle_expire),
        .en_i    ((state_q == StFill) && (cnt_q != '0)),
        .expire_o(idle_expire)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= idle_expire;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ byte_accept;
    assign idle_expire        = 1'b0;
    assign timeout_o          = 1'b0;
`endif

endmodule
